// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS:CC countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK  = 7'b111_1111;
  localparam logic [6:0] SEG_ZERO   = 7'b100_0000;
  localparam int         BLINK_HALF = 25;

  // Upper limit of each digit, index 0 = cs_lo ... index 5 = m_hi
  localparam bcd_t [5:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  function automatic bcd_t bcd_clamp(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low push key.
// Emits a one-cycle press pulse when a low level has been stable long enough.
module key_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic key_reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any return to the accepted level restarts the stability window
      if (r_sync2 != r_stable) begin
        if (r_cnt == CW'(DEBOUNCE)) begin
          r_stable <= r_sync2;
          r_press  <= ~r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/sevenseg.sv
// BCD to active-low 7-segment decoder (gfedcba); non-BCD codes blank the digit.
module sevenseg
  import countdown_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_ZERO;
      4'd1: o_seg = 7'b111_1001;
      4'd2: o_seg = 7'b010_0100;
      4'd3: o_seg = 7'b011_0000;
      4'd4: o_seg = 7'b001_1001;
      4'd5: o_seg = 7'b001_0010;
      4'd6: o_seg = 7'b000_0010;
      4'd7: o_seg = 7'b111_1000;
      4'd8: o_seg = 7'b000_0000;
      4'd9: o_seg = 7'b001_0000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// DE1-SoC countdown timer: MM:SS:CC down-count in 10 ms ticks from a switch preset.
// Define COUNTDOWN_BLINK_EN to blink the displays and led2 while expired.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int DEBOUNCE = 500000
) (
  input  logic       clk,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_load,
  input  logic [7:0] sw,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       led0,
  output logic       led1,
  output logic       led2
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic w_press_start;
  logic w_press_load;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_start (
    .clk       (clk),
    .key_reset (key_reset),
    .key_n     (key_start_pause),
    .press     (w_press_start)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_load (
    .clk       (clk),
    .key_reset (key_reset),
    .key_n     (key_load),
    .press     (w_press_load)
  );

  state_t          r_state;
  state_t          w_state_next;
  bcd_t   [5:0]    r_digits;
  bcd_t   [5:0]    w_digits_next;
  bcd_t   [5:0]    w_dec;
  bcd_t   [5:0]    w_preset;
  logic   [PW-1:0] r_presc;
  logic   [PW-1:0] w_presc_next;
  logic            w_count_en;
  logic            w_tick;
  logic            w_load;
  logic            w_dec_zero;
  logic            w_value_zero;
  logic            w_blank;

  assign w_preset     = {bcd_clamp(sw[7:4]), bcd_clamp(sw[3:0]), 16'h0000};
  assign w_value_zero = (r_digits == '0);
  assign w_dec_zero   = (w_dec == '0);

`ifdef COUNTDOWN_BLINK_EN
  assign w_count_en = (r_state == RUN) || (r_state == DONE);
`else
  assign w_count_en = (r_state == RUN);
`endif
  assign w_tick = w_count_en && (r_presc == PW'(TICK_DIV - 1));

  // One-centisecond decrement with borrow across all six digits
  always_comb begin : dec_chain
    logic borrow;
    borrow = 1'b1;
    w_dec  = r_digits;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (r_digits[i] == 4'd0) begin
          w_dec[i] = DIGIT_MAX[i];
        end else begin
          w_dec[i] = r_digits[i] - 4'd1;
          borrow   = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_digits_next = r_digits;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press_load) begin
          w_load = 1'b1;
        end else if (w_press_start && !w_value_zero) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_tick) begin
          w_digits_next = w_dec;
          if (w_dec_zero) w_state_next = DONE;
        end
        if (w_press_start && !(w_tick && w_dec_zero)) w_state_next = PAUSE;
      end
      PAUSE: begin
        if (w_press_load) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end else if (w_press_start) begin
          w_state_next = RUN;
        end
      end
      DONE: begin
        if (w_press_load) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_load) w_digits_next = w_preset;
  end

  // Prescaler holds through PAUSE so a resume finishes the partial tick
  always_comb begin
    w_presc_next = r_presc;
    if (w_load || (r_state == IDLE) ||
        ((w_state_next == DONE) && (r_state != DONE))) begin
      w_presc_next = '0;
    end else if (w_count_en) begin
      w_presc_next = w_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      r_state  <= IDLE;
      r_digits <= '0;
      r_presc  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_digits <= w_digits_next;
      r_presc  <= w_presc_next;
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  logic [4:0] r_blink_cnt;
  logic       r_blink_phase;

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_state != DONE) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == 5'(BLINK_HALF - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 5'd1;
      end
    end
  end

  assign w_blank = (r_state == DONE) && r_blink_phase;
  assign led2    = (r_state == DONE) && !r_blink_phase;
`else
  assign w_blank = 1'b0;
  assign led2    = (r_state == DONE);
`endif

  assign led0 = (r_state == RUN);
  assign led1 = (r_state == PAUSE);

  logic [6:0] w_seg_raw [6];
  logic [6:0] w_seg     [6];

  for (genvar gi = 0; gi < 6; gi++) begin : g_seg
    sevenseg u_seg (
      .i_bcd (r_digits[gi]),
      .o_seg (w_seg_raw[gi])
    );
    assign w_seg[gi] = w_blank ? SEG_BLANK : w_seg_raw[gi];
  end

  assign hex0 = w_seg[0];
  assign hex1 = w_seg[1];
  assign hex2 = w_seg[2];
  assign hex3 = w_seg[3];
  assign hex4 = w_seg[4];
  assign hex5 = w_seg[5];

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_DIV=4, DEBOUNCE=3.
module tb_countdown_timer;

  logic       clk;
  logic       key_reset;
  logic       key_start;
  logic       key_load;
  logic [7:0] sw;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       led0, led1, led2;

  int checks;
  int errors;
  int cyc;
  int t0;
  int t_run;
  int rises;
  logic saw_pause;
  logic prev_led0;

  countdown_timer #(.TICK_DIV(4), .DEBOUNCE(3)) dut (
    .clk             (clk),
    .key_reset       (key_reset),
    .key_start_pause (key_start),
    .key_load        (key_load),
    .sw              (sw),
    .hex0            (hex0),
    .hex1            (hex1),
    .hex2            (hex2),
    .hex3            (hex3),
    .hex4            (hex4),
    .hex5            (hex5),
    .led0            (led0),
    .led1            (led1),
    .led2            (led2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] exp_disp(input logic [23:0] v);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = seg_of(v[i*4 +: 4]);
    return r;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [23:0] v);
    chk(tag, 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(exp_disp(v)));
  endtask

  task automatic chk_leds(input string tag, input logic [2:0] exp);
    chk(tag, 64'({led2, led1, led0}), 64'(exp));
  endtask

  task automatic press(input logic do_start, input logic do_load);
    if (do_start) key_start = 1'b0;
    if (do_load)  key_load  = 1'b0;
    tick_n(8);
    key_start = 1'b1;
    key_load  = 1'b1;
    tick_n(8);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    key_reset = 1'b0;
    key_start = 1'b1;
    key_load  = 1'b1;
    sw        = 8'h00;

    // Reset state
    tick_n(2);
    chk_disp("reset_disp", 24'h000000);
    chk_leds("reset_leds", 3'b000);
    @(negedge clk) key_reset = 1'b1;
    tick_n(2);

    // Load 01 minute and run to expiry
    sw = 8'h01;
    press(1'b0, 1'b1);
    chk_disp("load_01", 24'h010000);
    chk_leds("load_01_leds", 3'b000);

    key_start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 20 && !led0; i++) tick_n(1);
    chk("start_latency", 64'(cyc - t0), 64'd7);
    t_run = cyc;
    tick_n(3);
    chk_disp("pre_first_tick", 24'h010000);
    key_start = 1'b1;
    tick_n(1);
    chk_disp("first_tick", 24'h005999);

    sw = 8'h22;
    press(1'b0, 1'b1);
    chk_disp("load_ignored_in_run", 24'h005995);
    chk_leds("still_running", 3'b001);

    for (int i = 0; i < 30000 && !led2; i++) tick_n(1);
    chk("done_time", 64'(cyc - t_run), 64'd24000);
    chk_disp("done_zero", 24'h000000);
    chk_leds("done_leds", 3'b100);

`ifdef COUNTDOWN_BLINK_EN
    tick_n(50);
    chk_disp("blink_on", 24'h000000);
    tick_n(100);
    chk("blink_off", 64'({hex5, hex4, hex3, hex2, hex1, hex0, led2}), 64'({42'h3FFFFFFFFFF, 1'b0}));
    tick_n(100);
    chk_disp("blink_on_again", 24'h000000);
    chk("blink_led_on", 64'(led2), 64'd1);
`endif

    press(1'b1, 1'b0);
    chk("done_start_ignored", 64'({led1, led0}), 64'd0);

    // Clamp and zero-start
    sw = 8'hFA;
    press(1'b0, 1'b1);
    chk_disp("clamp_99", 24'h990000);
    chk_leds("clamp_leds", 3'b000);
    sw = 8'h00;
    press(1'b0, 1'b1);
    chk_disp("load_zero", 24'h000000);
    press(1'b1, 1'b0);
    chk_leds("zero_start_ignored", 3'b000);

    // Bouncing start key gives one press
    sw = 8'h01;
    press(1'b0, 1'b1);
    chk_disp("reload_01", 24'h010000);
    rises     = 0;
    saw_pause = 1'b0;
    prev_led0 = led0;
    for (int i = 0; i < 60; i++) begin
      if (i < 20)      key_start = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else if (i < 50) key_start = 1'b0;
      else             key_start = 1'b1;
      tick_n(1);
      if (led0 && !prev_led0) rises++;
      if (led1) saw_pause = 1'b1;
      prev_led0 = led0;
    end
    chk("bounce_rises", 64'(rises), 64'd1);
    chk("bounce_no_pause", 64'(saw_pause), 64'd0);
    chk("bounce_running", 64'(led0), 64'd1);

    // Pause, then load+start together
    press(1'b1, 1'b0);
    chk_leds("paused", 3'b010);
    press(1'b1, 1'b1);
    chk_disp("both_keys_preset", 24'h010000);
    chk_leds("both_keys_idle", 3'b000);

    // Pause after 3 ticks, hold, and resume the partial tick
    key_start = 1'b0;
    tick_n(8);
    key_start = 1'b1;
    tick_n(6);
    key_start = 1'b0;
    tick_n(5);
    chk_disp("three_ticks", 24'h005997);
    chk_leds("three_ticks_run", 3'b001);
    tick_n(1);
    chk_disp("pre_pause", 24'h005997);
    tick_n(1);
    chk_leds("pause_entered", 3'b010);
    chk_disp("pause_value", 24'h005997);
    key_start = 1'b1;
    tick_n(50);
    chk_disp("pause_hold", 24'h005997);
    chk_leds("pause_hold_leds", 3'b010);

    key_start = 1'b0;
    tick_n(6);
    chk_leds("resume_not_yet", 3'b010);
    tick_n(1);
    chk_leds("resume_run", 3'b001);
    chk_disp("resume_value", 24'h005997);
    tick_n(1);
    chk_disp("resume_partial", 24'h005997);
    tick_n(1);
    chk_disp("resume_tick", 24'h005996);
    tick_n(4);
    chk_disp("next_full_tick", 24'h005995);
    key_start = 1'b1;

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3 key_reset = 1'b0;
    #1;
    chk_disp("async_reset_disp", 24'h000000);
    chk_leds("async_reset_leds", 3'b000);
    @(negedge clk) key_reset = 1'b1;
    tick_n(4);
    chk_disp("after_reset_no_reload", 24'h000000);
    chk_leds("after_reset_idle", 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
